// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared control encodings for the multi-cycle controller.
// State, instruction-class, mux-select, ALU and extender codes.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXE,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_ORI,
    C_ADDIU,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL,
    C_ILL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO    = 2'b00;
  localparam logic [1:0] EXT_SIGNED  = 2'b01;
  localparam logic [1:0] EXT_HIGHPOS = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  function automatic logic is_itype(cls_t c);
    return (c == C_ORI) || (c == C_ADDIU) ||
           (c == C_LUI) || (c == C_LW) ||
           (c == C_SW);
  endfunction

  function automatic logic [1:0] ext_sel(cls_t c);
    logic [1:0] e;
    unique case (c)
      C_LUI:   e = EXT_HIGHPOS;
      C_ADDIU,
      C_LW,
      C_SW,
      C_BEQ:   e = EXT_SIGNED;
      default: e = EXT_ZERO;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Op/Funct to instruction class and ALU operation.
// Purely combinational; anything unrecognised maps to C_ILL.
module ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output cls_t       cls,
  output logic [2:0] alu_op
);

  always_comb begin
    cls    = C_ILL;
    alu_op = ALU_ADD;
    unique case (Op)
      OP_RTYPE: begin
        unique case (Funct)
          FN_ADDU: begin cls = C_RTYPE; alu_op = ALU_ADD; end
          FN_SUBU: begin cls = C_RTYPE; alu_op = ALU_SUB; end
          FN_SLT:  begin cls = C_RTYPE; alu_op = ALU_SLT; end
          FN_AND:  begin cls = C_RTYPE; alu_op = ALU_AND; end
          FN_OR:   begin cls = C_RTYPE; alu_op = ALU_OR;  end
          default: cls = C_ILL;
        endcase
      end
      OP_ORI:   begin cls = C_ORI;   alu_op = ALU_OR;  end
      OP_ADDIU: begin cls = C_ADDIU; alu_op = ALU_ADD; end
      OP_LUI:   begin cls = C_LUI;   alu_op = ALU_LUI; end
      OP_LW:    begin cls = C_LW;    alu_op = ALU_ADD; end
      OP_SW:    begin cls = C_SW;    alu_op = ALU_ADD; end
      OP_BEQ:   begin cls = C_BEQ;   alu_op = ALU_SUB; end
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      default:  cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXE/MEM/WB FSM
// with Moore-decoded datapath controls and a retired-instruction count.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWr,
  output logic [1:0]  NPCOp,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [1:0]  ExtOp,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        Illegal,
  output logic [31:0] InstrCnt
);

  state_t     state;
  state_t     nstate;
  cls_t       cls;
  logic [2:0] alu_op;
  logic       retire;

  ctrl_decode u_decode (
    .Op     (Op),
    .Funct  (Funct),
    .cls    (cls),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      InstrCnt <= '0;
    end else begin
      state <= nstate;
      if (retire) InstrCnt <= InstrCnt + 32'd1;
    end
  end

  always_comb begin
    nstate  = state;
    retire  = 1'b0;
    PCWr    = 1'b0;
    NPCOp   = NPC_PC4;
    IRWr    = 1'b0;
    RegWr   = 1'b0;
    MemWr   = 1'b0;
    ExtOp   = EXT_ZERO;
    ALUSrcB = 1'b0;
    ALUOp   = ALU_ADD;
    RegDst  = RD_RT;
    WDSel   = WD_ALU;
    Illegal = 1'b0;
    unique case (state)
      S_FETCH: begin
        IRWr   = 1'b1;
        PCWr   = 1'b1;
        nstate = S_DECODE;
      end
      S_DECODE: begin
        unique case (cls)
          C_ILL: begin
            Illegal = 1'b1;
            nstate  = S_FETCH;
          end
          C_J: begin
            PCWr   = 1'b1;
            NPCOp  = NPC_JMP;
            nstate = S_FETCH;
            retire = 1'b1;
          end
          C_JAL: begin
            PCWr   = 1'b1;
            NPCOp  = NPC_JMP;
            nstate = S_WB;
          end
          default: nstate = S_EXE;
        endcase
      end
      S_EXE: begin
        ALUOp   = alu_op;
        ALUSrcB = is_itype(cls);
        ExtOp   = ext_sel(cls);
        unique case (1'b1)
          cls == C_BEQ: begin
            PCWr   = Zero;
            NPCOp  = NPC_BR;
            nstate = S_FETCH;
            retire = 1'b1;
          end
          cls == C_LW,
          cls == C_SW: nstate = S_MEM;
          default:     nstate = S_WB;
        endcase
      end
      S_MEM: begin
        ExtOp = ext_sel(cls);
        MemWr = (cls == C_SW);
        if (MemReady) begin
          if (cls == C_LW) begin
            nstate = S_WB;
          end else begin
            nstate = S_FETCH;
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        RegWr = 1'b1;
        unique case (1'b1)
          cls == C_RTYPE: RegDst = RD_RD;
          cls == C_JAL:   RegDst = RD_RA;
          default:        RegDst = RD_RT;
        endcase
        unique case (1'b1)
          cls == C_LW:  WDSel = WD_MEM;
          cls == C_JAL: WDSel = WD_PC4;
          default:      WDSel = WD_ALU;
        endcase
        nstate = S_FETCH;
        retire = 1'b1;
      end
      default: nstate = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl against a per-instruction
// cycle-list reference model.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        MemReady;
  logic        PCWr;
  logic [1:0]  NPCOp;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic [1:0]  ExtOp;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic        Illegal;
  logic [31:0] InstrCnt;

  multi_cycle_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWr     (PCWr),
    .NPCOp    (NPCOp),
    .IRWr     (IRWr),
    .RegWr    (RegWr),
    .MemWr    (MemWr),
    .ExtOp    (ExtOp),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .RegDst   (RegDst),
    .WDSel    (WDSel),
    .Illegal  (Illegal),
    .InstrCnt (InstrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwr;
    logic [1:0] npc;
    logic       irwr;
    logic       regwr;
    logic       memwr;
    logic [1:0] ext;
    logic       srcb;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       ill;
  } cyc_t;

  localparam int K_ADDU  = 0;
  localparam int K_SUBU  = 1;
  localparam int K_SLT   = 2;
  localparam int K_AND   = 3;
  localparam int K_OR    = 4;
  localparam int K_ORI   = 5;
  localparam int K_ADDIU = 6;
  localparam int K_LUI   = 7;
  localparam int K_LW    = 8;
  localparam int K_SW    = 9;
  localparam int K_BEQ   = 10;
  localparam int K_J     = 11;
  localparam int K_JAL   = 12;
  localparam int K_ILLOP = 13;
  localparam int K_ILLFN = 14;
  localparam int NK      = 15;

  int          n_chk;
  int          n_fail;
  logic [31:0] exp_cnt;
  cyc_t        exp_q[$];
  logic        mr_q[$];

  function automatic cyc_t observe();
    return {PCWr, NPCOp, IRWr, RegWr, MemWr, ExtOp, ALUSrcB,
            ALUOp, RegDst, WDSel, Illegal};
  endfunction

  function automatic logic [5:0] op_of(int k);
    case (k)
      K_ORI:   return 6'b001101;
      K_ADDIU: return 6'b001001;
      K_LUI:   return 6'b001111;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      K_JAL:   return 6'b000011;
      K_ILLOP: return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] fn_of(int k);
    case (k)
      K_ADDU:  return 6'b100001;
      K_SUBU:  return 6'b100011;
      K_SLT:   return 6'b101010;
      K_AND:   return 6'b100100;
      K_OR:    return 6'b100101;
      K_ILLFN: return 6'b000000;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] alu_of(int k);
    case (k)
      K_SUBU, K_BEQ: return ALU_SUB;
      K_SLT:         return ALU_SLT;
      K_AND:         return ALU_AND;
      K_OR, K_ORI:   return ALU_OR;
      K_LUI:         return ALU_LUI;
      default:       return ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] ext_of(int k);
    case (k)
      K_ORI:                       return EXT_ZERO;
      K_LUI:                       return EXT_HIGHPOS;
      K_ADDIU, K_LW, K_SW, K_BEQ:  return EXT_SIGNED;
      default:                     return EXT_ZERO;
    endcase
  endfunction

  // Build the expected per-cycle control trace of one instruction.
  task automatic build(input int k, input int waits, input logic z);
    cyc_t c;
    bit   rtype;
    rtype = (k <= K_OR);
    exp_q = {};
    mr_q  = {};
    c = '0; c.irwr = 1'b1; c.pcwr = 1'b1;
    exp_q.push_back(c); mr_q.push_back(1'($urandom));
    c = '0;
    if (k == K_ILLOP || k == K_ILLFN) begin
      c.ill = 1'b1;
      exp_q.push_back(c); mr_q.push_back(1'($urandom));
    end else if (k == K_J || k == K_JAL) begin
      c.pcwr = 1'b1; c.npc = 2'b10;
      exp_q.push_back(c); mr_q.push_back(1'($urandom));
      if (k == K_JAL) begin
        c = '0; c.regwr = 1'b1; c.regdst = 2'b10; c.wdsel = 2'b10;
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
      end
    end else begin
      exp_q.push_back(c); mr_q.push_back(1'($urandom));
      c = '0;
      c.aluop = alu_of(k);
      c.ext   = ext_of(k);
      c.srcb  = !rtype && (k != K_BEQ);
      if (k == K_BEQ) begin
        c.pcwr = z; c.npc = 2'b01;
      end
      exp_q.push_back(c); mr_q.push_back(1'($urandom));
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i <= waits; i++) begin
          c = '0; c.ext = EXT_SIGNED; c.memwr = (k == K_SW);
          exp_q.push_back(c); mr_q.push_back(i == waits);
        end
      end
      if (k != K_SW && k != K_BEQ) begin
        c = '0; c.regwr = 1'b1;
        c.regdst = rtype ? 2'b01 : 2'b00;
        c.wdsel  = (k == K_LW) ? 2'b01 : 2'b00;
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
      end
    end
  endtask

  // Entered just after a falling edge with the DUT in FETCH.
  task automatic run(input int k, input int waits, input logic z,
                     input string tag);
    cyc_t obs;
    build(k, waits, z);
    Op    = op_of(k);
    Funct = fn_of(k);
    Zero  = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      MemReady = mr_q[i];
      if (k != K_BEQ) Zero = 1'($urandom);
      #1;
      obs = observe();
      n_chk++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h",
                 tag, i, obs, exp_q[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (k != K_ILLOP && k != K_ILLFN) exp_cnt = exp_cnt + 32'd1;
    #1;
    n_chk++;
    if (IRWr !== 1'b1 || InstrCnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s end: IRWr=%b InstrCnt=%0d required IRWr=1 InstrCnt=%0d",
               tag, IRWr, InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    cyc_t fc;
    rst = 1'b1;
    Op = 6'b100011; Funct = '0; Zero = 1'b0; MemReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    fc = '0; fc.irwr = 1'b1; fc.pcwr = 1'b1;
    n_chk++;
    if (observe() !== fc || InstrCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: got %h cnt %0d required %h cnt 0",
               observe(), InstrCnt, fc);
    end
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ori();
    run(K_ORI, 0, 1'b0, "ori");
  endtask

  task automatic test_lw_wait();
    run(K_LW, 3, 1'b0, "lw_wait3");
  endtask

  task automatic test_beq();
    run(K_BEQ, 0, 1'b1, "beq_taken");
    run(K_BEQ, 0, 1'b0, "beq_not_taken");
  endtask

  task automatic test_jal();
    run(K_JAL, 0, 1'b0, "jal");
  endtask

  task automatic test_illegal();
    run(K_ILLOP, 0, 1'b0, "illegal_op");
    run(K_ILLFN, 0, 1'b0, "illegal_funct");
  endtask

  task automatic test_reset_mid_sw();
    Op = op_of(K_SW); Funct = '0; MemReady = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (MemWr !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_mem_wait: MemWr=%b required 1", MemWr);
    end
    #1 rst = 1'b1;
    #1;
    exp_cnt = '0;
    n_chk++;
    if (MemWr !== 1'b0 || IRWr !== 1'b1 || InstrCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_sw: MemWr=%b IRWr=%b cnt=%0d required 0 1 0",
               MemWr, IRWr, InstrCnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(K_ORI, 0, 1'b0, "ori_after_rst");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(NK - 1, 0);
      run(k, $urandom_range(3, 0), 1'($urandom),
          $sformatf("rand%0d_k%0d", n, k));
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = '0;
    test_reset();
    test_ori();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    run(K_SW, 2, 1'b0, "sw_wait2");
    run(K_J, 0, 1'b0, "j");
    run(K_SLT, 0, 1'b0, "slt");
    run(K_LUI, 0, 1'b0, "lui");
    test_back_to_back();
    test_reset_mid_sw();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings come from the shared control header CtrlDef.v.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 Op  input  6  opcode field of the instruction register.
REQ-005 Funct  input  6  function field of the instruction register.
REQ-006 Zero  input  1  ALU zero flag, sampled in EXE.
REQ-007 MemReady  input  1  data-memory ready handshake, sampled in MEM.
REQ-008 PCWr  output  1  PC write enable.
REQ-009 NPCOp  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 IRWr  output  1  instruction register write enable.
REQ-011 RegWr  output  1  register file write enable.
REQ-012 MemWr  output  1  data memory write strobe.
REQ-013 ExtOp  output  2  immediate extender select (EXT_ZERO, EXT_SIGNED, EXT_HIGHPOS).
REQ-014 ALUSrcB  output  1  0 = register B, 1 = extended immediate.
REQ-015 ALUOp  output  3  ALU operation code from CtrlDef.v.
REQ-016 RegDst  output  2  00 rt, 01 rd, 10 register 31.
REQ-017 WDSel  output  2  00 ALU result, 01 memory data, 10 PC+4.
REQ-018 Illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-019 InstrCnt  output  32  count of retired instructions.

Function
REQ-020 The FSM SHALL have the states FETCH, DECODE, EXE, MEM and WB.
REQ-021 Supported instructions SHALL be addu, subu, slt, and, or (R-type), ori, addiu, lui, lw, sw, beq, j and jal.
REQ-022 Every instruction SHALL pass FETCH->DECODE; FETCH asserts IRWr=1, PCWr=1, NPCOp=00.
REQ-023 R-type, ori, addiu and lui SHALL take DECODE->EXE->WB->FETCH (4 cycles).
REQ-024 lw SHALL take DECODE->EXE->MEM->WB->FETCH (5 cycles minimum); sw SHALL take DECODE->EXE->MEM->FETCH.
REQ-025 The FSM SHALL stay in MEM while MemReady=0.
REQ-026 In MEM, MemWr SHALL be held for sw for every cycle of the wait; the transition leaves MEM on the first cycle with MemReady=1.
REQ-027 beq SHALL take DECODE->EXE->FETCH; in EXE, PCWr=Zero and NPCOp=01.
REQ-028 j SHALL take DECODE->FETCH with PCWr=1 and NPCOp=10 in DECODE.
REQ-029 jal SHALL take DECODE->WB->FETCH, with PCWr=1 and NPCOp=10 in DECODE.
REQ-030 In WB, jal SHALL assert RegWr=1, RegDst=10 and WDSel=10.
REQ-031 ExtOp SHALL be EXT_ZERO for ori, EXT_HIGHPOS for lui and EXT_SIGNED for addiu, lw, sw and beq.
REQ-032 ExtOp SHALL be held valid throughout EXE and MEM.
REQ-033 In WB, RegDst SHALL be 01 for R-type and 00 for I-type.
REQ-034 In WB, WDSel SHALL be 01 for lw and 00 otherwise.
REQ-035 RegWr SHALL be asserted only in WB.
REQ-036 In EXE, ALUSrcB SHALL be 1 for all I-type instructions and 0 for R-type and beq.
REQ-037 An unknown opcode, or an unknown funct with Op=000000, in DECODE SHALL pulse Illegal and return to FETCH.
REQ-038 An illegal instruction SHALL cause no writes and SHALL NOT increment InstrCnt.
REQ-039 InstrCnt SHALL increment by 1 on every transition into FETCH from a legal instruction's final state.
REQ-040 InstrCnt SHALL wrap from FFFFFFFF to 0.
REQ-041 All outputs other than InstrCnt SHALL be Moore-decoded from the state plus Op/Funct.
REQ-042 Outputs not named as active in a state SHALL be 0.

Reset
REQ-043 While rst=1, the state SHALL be FETCH and InstrCnt SHALL be 0, taking effect asynchronously.
REQ-044 A reset mid-instruction SHALL abandon the instruction with no further writes.
REQ-045 After rst deasserts, the first rising edge SHALL perform a normal FETCH.

Structure
REQ-046 State encodings, NPCOp, RegDst, WDSel, ALUOp and EXT_* codes SHALL live in CtrlDef.v.
REQ-047 The design SHALL contain one sub-module, ctrl_decode: combinational Op/Funct to instruction-class and ALUOp decode.
REQ-048 State register and InstrCnt SHALL be in multi_cycle_ctrl.

Verification
REQ-049 ori (Op=001101): the bench SHALL see 4 cycles, ExtOp=EXT_ZERO and ALUSrcB=1 in EXE, RegWr=1 with RegDst=00 in WB, and InstrCnt +1.
REQ-050 lw with MemReady low 3 cycles: the bench SHALL see MEM held 4 cycles, WB with WDSel=01, and 8 cycles total.
REQ-051 beq with Zero=1 then Zero=0: the bench SHALL see PCWr=1/NPCOp=01 in EXE, then PCWr=0, with 3 cycles each.
REQ-052 jal: the bench SHALL see PCWr=1/NPCOp=10 in DECODE and WB with RegDst=10, WDSel=10, RegWr=1.
REQ-053 Op=111111: the bench SHALL see a 1-cycle Illegal pulse in DECODE, no RegWr/MemWr, unchanged InstrCnt, and FETCH next.
REQ-054 rst asserted mid-MEM of sw: the bench SHALL see MemWr drop immediately, state=FETCH, InstrCnt=0.
